// File: rtl/pcihellocore_io_pkg.sv
// +----------------------------------------------------------------------+
// | pcihellocore_io_pkg: shared constants for the board I/O conditioners |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package pcihellocore_io_pkg;

    localparam int SW_WIDTH                = 32;
    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pcihellocore_debounce_bit.sv
// +----------------------------------------------------------------------+
// | pcihellocore_debounce_bit: one-bit synchroniser, stability counter   |
// | and accepted-level register with a one-cycle change pulse            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module pcihellocore_debounce_bit #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 17
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_i,
    output logic clean_o,
    output logic pulse_o,
    output logic accept_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   stable_q;
    logic                   stable_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   pulse_q;
    logic                   accept_d;
    logic                   sync_w;

    assign sync_w   = sync_q[SYNC_STAGES-1];
    assign clean_o  = stable_q;
    assign pulse_o  = pulse_q;
    // Next-cycle pulse, exposed so the top can register the OR alongside pulse_q.
    assign accept_o = accept_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        accept_d = 1'b0;
        if (sync_w != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_w;
                accept_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], raw_i};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            pulse_q  <= accept_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pcihellocore_switch_conditioner.sv
// +----------------------------------------------------------------------+
// | pcihellocore_switch_conditioner: synchronise and debounce the board  |
// | switches into a clean word for the PIO, plus per-bit change pulses   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module pcihellocore_switch_conditioner
    import pcihellocore_io_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] change_pulse,
    output logic             any_change
);

    localparam int CNT_W = clog2(DEBOUNCE_CYCLES) + 1;

    logic [WIDTH-1:0] accept_w;
    logic             any_change_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pcihellocore_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk      (clk),
            .reset_n  (reset_n),
            .raw_i    (sw_raw[i]),
            .clean_o  (sw_clean[i]),
            .pulse_o  (change_pulse[i]),
            .accept_o (accept_w[i])
        );
    end

    // Reduce the pre-register accepts so any_change lands on the same edge as change_pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            any_change_q <= 1'b0;
        end else begin
            any_change_q <= |accept_w;
        end
    end

    assign any_change = any_change_q;

endmodule

`default_nettype wire

// File: tb/tb_pcihellocore_switch_conditioner.sv
// +----------------------------------------------------------------------+
// | tb_pcihellocore_switch_conditioner: directed and random stimulus     |
// | checked against a run-length reference model                         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_pcihellocore_switch_conditioner;

    localparam int W = 32;
    localparam int S = 2;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic [W-1:0] sw_raw = '1;
    logic [W-1:0] sw_clean;
    logic [W-1:0] change_pulse;
    logic         any_change;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: a level is accepted once the synchronised value has differed
    // from the accepted level for D consecutive samples.
    logic [W-1:0] m_clean;
    logic [W-1:0] m_pulse;
    logic         m_any;
    logic [W-1:0] m_sh [S];
    logic [W-1:0] m_prev;
    int           m_run [W];

    pcihellocore_switch_conditioner #(
        .WIDTH           (W),
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sw_raw       (sw_raw),
        .sw_clean     (sw_clean),
        .change_pulse (change_pulse),
        .any_change   (any_change)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        m_clean = '0;
        m_pulse = '0;
        m_any   = 1'b0;
        m_prev  = '0;
        for (int k = 0; k < S; k++) m_sh[k] = '0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
    endtask

    task automatic tick();
        logic [W-1:0] s;
        @(posedge clk);
        if (!reset_n) begin
            model_clear();
        end else begin
            s       = m_sh[S-1];
            m_pulse = '0;
            for (int i = 0; i < W; i++) begin
                if (s[i] == m_prev[i]) begin
                    if (m_run[i] < D) m_run[i] = m_run[i] + 1;
                end else begin
                    m_run[i] = 1;
                end
                if (s[i] != m_clean[i] && m_run[i] >= D) m_pulse[i] = 1'b1;
            end
            m_prev  = s;
            m_any   = |m_pulse;
            m_clean = m_clean ^ m_pulse;
            for (int k = S - 1; k > 0; k--) m_sh[k] = m_sh[k-1];
            m_sh[0] = sw_raw;
        end
        #1;
    endtask

    task automatic drive(input logic [W-1:0] v);
        @(negedge clk);
        sw_raw = v;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        model_clear();
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++;
            if (sw_clean !== '0 || change_pulse !== '0 || any_change !== 1'b0) begin
                n_bad++;
                $display("FAIL reset: clean=%h pulse=%h any=%b required all 0", sw_clean, change_pulse, any_change);
            end
        end
    endtask

    task automatic test_single_rise();
        drive('0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        drive(32'h1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_cmp++;
            if (sw_clean !== m_clean || change_pulse !== m_pulse || any_change !== m_any) begin
                n_bad++;
                $display("FAIL rise model k=%0d: clean=%h pulse=%h any=%b required %h %h %b",
                         k, sw_clean, change_pulse, any_change, m_clean, m_pulse, m_any);
            end
            if (k == 5) begin
                n_cmp++;
                if (sw_clean[0] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rise early: clean[0]=%b required 0", sw_clean[0]);
                end
            end
            if (k == 6) begin
                n_cmp++;
                if (sw_clean !== 32'h1 || change_pulse !== 32'h1 || any_change !== 1'b1) begin
                    n_bad++;
                    $display("FAIL rise edge6: clean=%h pulse=%h any=%b required 1 1 1", sw_clean, change_pulse, any_change);
                end
            end
            if (k == 7) begin
                n_cmp++;
                if (change_pulse !== '0 || any_change !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rise pulse width: pulse=%h any=%b required 0 0", change_pulse, any_change);
                end
            end
        end
    endtask

    task automatic test_glitch();
        drive(32'h9);
        tick(); tick(); tick();
        drive(32'h1);
        for (int k = 0; k < 8; k++) begin
            tick();
            n_cmp++;
            if (sw_clean !== 32'h1 || change_pulse !== '0 || any_change !== 1'b0) begin
                n_bad++;
                $display("FAIL glitch: clean=%h pulse=%h any=%b required 00000001 0 0", sw_clean, change_pulse, any_change);
            end
        end
    endtask

    task automatic test_bounce();
        int np;
        np = 0;
        for (int seg = 0; seg < 4; seg++) begin
            drive((seg % 2 == 0) ? 32'h81 : 32'h01);
            for (int k = 0; k < 2; k++) begin
                tick();
                if (change_pulse[7]) np++;
                n_cmp++;
                if (sw_clean !== m_clean || change_pulse !== m_pulse) begin
                    n_bad++;
                    $display("FAIL bounce model: clean=%h pulse=%h required %h %h", sw_clean, change_pulse, m_clean, m_pulse);
                end
            end
        end
        drive(32'h81);
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (change_pulse[7]) np++;
            if (k == 5 || k == 6) begin
                n_cmp++;
                if (sw_clean[7] !== (k == 6) || change_pulse[7] !== (k == 6)) begin
                    n_bad++;
                    $display("FAIL bounce k=%0d: clean[7]=%b pulse[7]=%b required %b", k, sw_clean[7], change_pulse[7], (k == 6));
                end
            end
        end
        n_cmp++;
        if (np != 1) begin
            n_bad++;
            $display("FAIL bounce pulses: got %0d required 1", np);
        end
    endtask

    task automatic test_multi();
        drive('0);
        for (int k = 0; k < 12; k++) tick();
        drive(32'hFFFF_0000);
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_cmp++;
            if (sw_clean !== m_clean || change_pulse !== m_pulse || any_change !== m_any) begin
                n_bad++;
                $display("FAIL multi model k=%0d: clean=%h pulse=%h any=%b required %h %h %b",
                         k, sw_clean, change_pulse, any_change, m_clean, m_pulse, m_any);
            end
            if (k == 5 || k == 6 || k == 7) begin
                n_cmp++;
                if (sw_clean !== ((k >= 6) ? 32'hFFFF_0000 : 32'h0) ||
                    change_pulse !== ((k == 6) ? 32'hFFFF_0000 : 32'h0) ||
                    any_change !== (k == 6)) begin
                    n_bad++;
                    $display("FAIL multi k=%0d: clean=%h pulse=%h any=%b", k, sw_clean, change_pulse, any_change);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int np;
        np = 0;
        drive(32'h2);
        for (int k = 0; k < 4; k++) tick();
        @(negedge clk);
        reset_n = 1'b0;
        model_clear();
        #1;
        n_cmp++;
        if (sw_clean !== '0 || change_pulse !== '0 || any_change !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset async: clean=%h pulse=%h any=%b required 0", sw_clean, change_pulse, any_change);
        end
        tick(); tick();
        n_cmp++;
        if (sw_clean !== '0) begin
            n_bad++;
            $display("FAIL midreset hold: clean=%h required 0", sw_clean);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (change_pulse[1]) np++;
            n_cmp++;
            if (sw_clean !== m_clean || change_pulse !== m_pulse || any_change !== m_any) begin
                n_bad++;
                $display("FAIL midreset model k=%0d: clean=%h pulse=%h any=%b required %h %h %b",
                         k, sw_clean, change_pulse, any_change, m_clean, m_pulse, m_any);
            end
            if (k == 5 || k == 6) begin
                n_cmp++;
                if (sw_clean !== ((k == 6) ? 32'h2 : 32'h0)) begin
                    n_bad++;
                    $display("FAIL midreset k=%0d: clean=%h", k, sw_clean);
                end
            end
        end
        n_cmp++;
        if (np != 1) begin
            n_bad++;
            $display("FAIL midreset pulses: got %0d required 1", np);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] v;
        v = sw_raw;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) v = v ^ ($urandom & $urandom);
            drive(v);
            tick();
            n_cmp++;
            if (sw_clean !== m_clean || change_pulse !== m_pulse || any_change !== m_any) begin
                n_bad++;
                $display("FAIL random c=%0d: clean=%h pulse=%h any=%b required %h %h %b",
                         c, sw_clean, change_pulse, any_change, m_clean, m_pulse, m_any);
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single_rise();
        test_glitch();
        test_bounce();
        test_multi();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
